// File: rtl/bitplane_packer.sv
// Bitplane packer: slices N_PIX-pixel blocks into 8 plane words tagged 1..8.
// Define BITPLANE_PACKER_PINGPONG_EN for two banks (fill one, emit the other).
module bitplane_packer #(
  parameter  int N_PIX            = 256,
  parameter  int BLOCKS_PER_FRAME = 256,
  localparam int BW               = $clog2(BLOCKS_PER_FRAME)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_PIX-1:0] out_data,
  output logic [3:0]       out_plane,
  output logic [BW-1:0]    out_block,
  output logic             out_last
);

`ifdef BITPLANE_PACKER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int   PW   = $clog2(N_PIX);
  localparam logic FLIP = 1'(NB - 1);

  typedef enum logic {B_FILL, B_EMIT} bank_st_e;

  logic [N_PIX-1:0] bank_q [NB][8];
  logic [N_PIX-1:0] bank_d [NB][8];
  bank_st_e         st_q [NB];
  bank_st_e         st_d [NB];
  logic             fill_q, fill_d;
  logic             emit_q, emit_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [3:0]       pl_q, pl_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             in_fire, out_fire;
  logic             last_pix, last_pl, last_blk;
  logic [2:0]       pidx;

  // A bank in B_EMIT is full: it either emits or waits its turn.
  assign in_ready  = (st_q[fill_q] == B_FILL);
  assign out_valid = (st_q[emit_q] == B_EMIT);
  assign pidx      = 3'(pl_q - 4'd1);
  assign out_data  = out_valid ? bank_q[emit_q][pidx] : '0;
  assign out_plane = pl_q;
  assign out_block = blk_q;
  assign out_last  = out_valid && last_pl && last_blk;

  always_comb begin
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    last_pix = (pix_q == PW'(N_PIX - 1));
    last_pl  = (pl_q == 4'd8);
    last_blk = (blk_q == BW'(BLOCKS_PER_FRAME - 1));
    bank_d   = bank_q;
    st_d     = st_q;
    fill_d   = fill_q;
    emit_d   = emit_q;
    pix_d    = pix_q;
    pl_d     = pl_q;
    blk_d    = blk_q;
    if (in_fire) begin
      for (int b = 0; b < 8; b++) begin
        bank_d[fill_q][b] =
          {bank_q[fill_q][b][N_PIX-2:0], in_pix[b]};
      end
      pix_d = last_pix ? '0 : pix_q + PW'(1);
      if (last_pix) begin
        st_d[fill_q] = B_EMIT;
        fill_d       = fill_q ^ FLIP;
      end
    end
    if (out_fire) begin
      pl_d = last_pl ? 4'd1 : pl_q + 4'd1;
      if (last_pl) begin
        st_d[emit_q] = B_FILL;
        emit_d       = emit_q ^ FLIP;
        blk_d        = last_blk ? '0 : blk_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NB; k++) begin
        st_q[k] <= B_FILL;
        for (int b = 0; b < 8; b++) begin
          bank_q[k][b] <= '0;
        end
      end
      fill_q <= 1'b0;
      emit_q <= 1'b0;
      pix_q  <= '0;
      pl_q   <= 4'd1;
      blk_q  <= '0;
    end else begin
      bank_q <= bank_d;
      st_q   <= st_d;
      fill_q <= fill_d;
      emit_q <= emit_d;
      pix_q  <= pix_d;
      pl_q   <= pl_d;
      blk_q  <= blk_d;
    end
  end

endmodule

// File: tb/tb_bitplane_packer.sv
// Directed bench for bitplane_packer: plane slicing, stalls,
// async reset, frame wrap and a random-gap run against a plane model.
module tb_bitplane_packer;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_pix = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_data;
  logic [3:0]   out_plane;
  logic [7:0]   out_block;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit pp;

  logic [7:0]   pixmem [4][N];
  logic [N-1:0] q_data [$];
  int           q_pl [$];
  int           q_blk [$];
  int           q_last [$];
  int           q_cyc [$];

  bitplane_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_plane (out_plane),
    .out_block (out_block),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_pl.push_back(int'(out_plane));
      q_blk.push_back(int'(out_block));
      q_last.push_back(int'(out_last));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] word(input int b, input int p);
    logic [N-1:0] w;
    for (int i = 0; i < N; i++) w[N-1-i] = pixmem[b][i][p-1];
    return w;
  endfunction

  task automatic clearq();
    q_data.delete();
    q_pl.delete();
    q_blk.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [7:0] p);
    bit rdy;
    int t;
    in_valid = 1'b1;
    in_pix   = p;
    t = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      if (rdy) last_acc = cyc;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 5000);
    if (!rdy) chk("push_timeout", 256'(in_ready), 256'(1));
  endtask

  task automatic feed(input int k);
    for (int i = 0; i < N; i++) push(pixmem[k][i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (q_data.size() < n && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (q_data.size() < n) chk("wait_words", 256'(q_data.size()), 256'(n));
  endtask

  initial begin
    int nlast;
    int bad;
    logic [N-1:0] exp;
`ifdef BITPLANE_PACKER_PINGPONG_EN
    pp = 1'b1;
`else
    pp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_plane", 256'(out_plane), 256'(1));
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All 0xA5: bits 0,2,5,7 set
    clearq();
    for (int i = 0; i < N; i++) pixmem[0][i] = 8'hA5;
    feed(0);
    wait_words(8);
    for (int p = 1; p <= 8; p++) begin
      exp = (p == 1 || p == 3 || p == 6 || p == 8) ? {N{1'b1}} : {N{1'b0}};
      chk($sformatf("a5_word%0d", p), q_data[p-1], exp);
      chk($sformatf("a5_plane%0d", p), 256'(q_pl[p-1]), 256'(p));
    end
    chk("a5_latency", 256'(q_cyc[0]), 256'(last_acc + 1));
    chk("a5_back2back", 256'(q_cyc[7] - q_cyc[0]), 256'(7));
    chk("a5_block", 256'(q_blk[7]), 256'(0));

    // Ramp: pixel i = i
    clearq();
    for (int i = 0; i < N; i++) pixmem[1][i] = 8'(i);
    feed(1);
    wait_words(8);
    chk("ramp_plane1", q_data[0], {128{2'b01}});
    chk("ramp_plane8", q_data[7], {{128{1'b0}}, {128{1'b1}}});
    chk("ramp_plane4", q_data[3], word(1, 4));
    chk("ramp_block", 256'(q_blk[0]), 256'(1));

    // Stall on plane 3 for 5 cycles
    clearq();
    for (int i = 0; i < N; i++) pixmem[2][i] = 8'(i * 7);
    out_ready = 1'b0;
    feed(2);
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_plane", 256'(out_plane), 256'(3));
      chk("stall_data", out_data, word(2, 3));
      chk("stall_in_ready", 256'(in_ready), 256'(pp));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_words(8);
    for (int p = 1; p <= 8; p++) begin
      chk($sformatf("stall_word%0d", p), q_data[p-1], word(2, p));
    end
    chk("stall_gap", 256'(q_cyc[2] - q_cyc[1]), 256'(6));
    chk("stall_block", 256'(q_blk[0]), 256'(2));

    // Async reset mid-emit
    clearq();
    for (int i = 0; i < N; i++) pixmem[3][i] = 8'(i);
    feed(3);
    wait_words(3);
    @(negedge clk);
    #2;
    chk("pre_rst_block", 256'(out_block), 256'(3));
    chk("pre_rst_valid", 256'(out_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 256'(out_valid), 256'(0));
    chk("async_in_ready", 256'(in_ready), 256'(1));
    chk("async_out_plane", 256'(out_plane), 256'(1));
    chk("async_out_block", 256'(out_block), 256'(0));
    chk("async_out_data", out_data, '0);
    chk("async_out_last", 256'(out_last), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame: out_last only on block 255 plane 8
    clearq();
    for (int b = 0; b < 256; b++) begin
      for (int i = 0; i < N; i++) pixmem[0][i] = 8'(i ^ b);
      feed(0);
    end
    wait_words(2048);
    chk("frame_words", 256'(q_data.size()), 256'(2048));
    nlast = 0;
    bad = 0;
    for (int k = 0; k < q_data.size(); k++) begin
      if (q_last[k] != 0) nlast++;
      if (q_blk[k] != k / 8 || q_pl[k] != (k % 8) + 1) bad++;
    end
    chk("frame_last_count", 256'(nlast), 256'(1));
    chk("frame_last_flag", 256'(q_last[2047]), 256'(1));
    chk("frame_last_block", 256'(q_blk[2047]), 256'(255));
    chk("frame_last_plane", 256'(q_pl[2047]), 256'(8));
    chk("frame_order_bad", 256'(bad), 256'(0));

    // Random gaps on both sides, next frame wraps to block 0
    clearq();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < N; i++) pixmem[b][i] = 8'($urandom);
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0;
              repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
              end
            end
            push(pixmem[b][i]);
          end
        end
        in_valid = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (q_data.size() < 32 && t < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          t++;
        end
        out_ready = 1'b1;
      end
    join
    wait_words(32);
    chk("rand_words", 256'(q_data.size()), 256'(32));
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("rand_data%0d", k), q_data[k], word(k / 8, (k % 8) + 1));
      chk($sformatf("rand_plane%0d", k), 256'(q_pl[k]), 256'((k % 8) + 1));
      chk($sformatf("rand_block%0d", k), 256'(q_blk[k]), 256'(k / 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
